// File: rtl/registradores.sv
// registradores: register file with 2**ADDR_W words of DATA_W bits.
// Register x0 always reads as zero and ignores writes.
// There are two combinational read ports and one synchronous write port.
// A write in flight is forwarded to a read port that addresses the same
// register, so a read sees the new value as soon as it is presented.
// rst_n is asynchronous and active-low. It clears every register, blocks
// writes, and forces both read ports to zero while it is held low.
module registradores #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic              w_writeEn;
  logic              w_bypass1;
  logic              w_bypass2;
  logic [DATA_W-1:0] w_read1;
  logic [DATA_W-1:0] w_read2;

  // A write is effective only for a nonzero target outside of reset
  always_comb begin
    w_writeEn = wr && (rd != '0) && rst_n;
    w_bypass1 = w_writeEn && (rs1 == rd);
    w_bypass2 = w_writeEn && (rs2 == rd);
  end

  // Storage: asynchronous clear, single write per rising edge, x0 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeEn) begin
      r_regs[rd] <= wr_data;
    end
  end

  // Read port 1: zero in reset or for x0, forwarded write data, else stored word
  always_comb begin
    w_read1 = '0;
    if (rst_n && (rs1 != '0)) begin
      if (w_bypass1) begin
        w_read1 = wr_data;
      end else begin
        w_read1 = r_regs[rs1];
      end
    end
  end

  // Read port 2: same rules as port 1, fully independent of it
  always_comb begin
    w_read2 = '0;
    if (rst_n && (rs2 != '0)) begin
      if (w_bypass2) begin
        w_read2 = wr_data;
      end else begin
        w_read2 = r_regs[rs2];
      end
    end
  end

  assign read1 = w_read1;
  assign read2 = w_read2;

endmodule

// File: tb/tb_registradores.sv
// tb_registradores: directed and randomized checks of the register file
// against an array-based reference model.
module tb_registradores;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] wr_data;
  logic              wr;
  logic [DATA_W-1:0] read1;
  logic [DATA_W-1:0] read2;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model [32];

  registradores #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rs1(rs1),
    .rs2(rs2),
    .rd(rd),
    .wr_data(wr_data),
    .wr(wr),
    .read1(read1),
    .read2(read2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read: zero in reset or for x0, write data when that register is being written, else stored value
  function automatic logic [DATA_W-1:0] expRead(input logic [ADDR_W-1:0] idx);
    if (!rst_n || idx == 0) return '0;
    if (wr && rd == idx) return wr_data;
    return model[idx];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Advance one rising edge, update the model, and settle just after the edge
  task automatic tick();
    @(posedge clk);
    if (rst_n && wr && rd != 0) model[rd] = wr_data;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b0; rd = '0; wr_data = '0; rs1 = '0; rs2 = '0;
    clearModel();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (read1 !== 0 || read2 !== 0) begin
      errors++; $display("[TB] FAIL reset_x0 read1=%h read2=%h required 0", read1, read2);
    end
    rs1 = 5'd1; rs2 = 5'd15; #1;
    checks++;
    if (read1 !== 0 || read2 !== 0) begin
      errors++; $display("[TB] FAIL reset_x1_x15 read1=%h read2=%h required 0", read1, read2);
    end
    rs1 = 5'd31; #1;
    checks++;
    if (read1 !== 0) begin
      errors++; $display("[TB] FAIL reset_x31 read1=%h required 0", read1);
    end
  endtask

  task automatic test_write_read();
    rd = 5'd10; wr_data = 32'hAAAABBBB; wr = 1'b1;
    tick();
    wr = 1'b0; rs1 = 5'd10; rs2 = 5'd20; #1;
    checks++;
    if (read1 !== 32'hAAAABBBB || read2 !== 32'h0) begin
      errors++; $display("[TB] FAIL write_x10 read1=%h read2=%h required AAAABBBB 00000000", read1, read2);
    end
    rd = 5'd20; wr_data = 32'hCCCCDDDD; wr = 1'b1;
    tick();
    wr = 1'b0; rs1 = 5'd0; rs2 = 5'd20; #1;
    checks++;
    if (read1 !== 32'h0 || read2 !== 32'hCCCCDDDD) begin
      errors++; $display("[TB] FAIL write_x20 read1=%h read2=%h required 00000000 CCCCDDDD", read1, read2);
    end
    rs1 = 5'd10; #1;
    checks++;
    if (read1 !== 32'hAAAABBBB) begin
      errors++; $display("[TB] FAIL x10_kept read1=%h required AAAABBBB", read1);
    end
  endtask

  task automatic test_x0();
    rd = 5'd0; wr_data = 32'hFFFFFFFF; wr = 1'b1; rs1 = 5'd0; rs2 = 5'd0; #1;
    checks++;
    if (read1 !== 32'h0) begin
      errors++; $display("[TB] FAIL x0_bypass read1=%h required 0", read1);
    end
    tick();
    wr = 1'b0; #1;
    checks++;
    if (read1 !== 32'h0 || read2 !== 32'h0) begin
      errors++; $display("[TB] FAIL x0_write read1=%h read2=%h required 0", read1, read2);
    end
    rs1 = 5'd10; rs2 = 5'd20; #1;
    checks++;
    if (read1 !== 32'hAAAABBBB || read2 !== 32'hCCCCDDDD) begin
      errors++; $display("[TB] FAIL x0_side_effect read1=%h read2=%h required AAAABBBB CCCCDDDD", read1, read2);
    end
  endtask

  task automatic test_bypass();
    rd = 5'd5; wr_data = 32'h12345678; wr = 1'b1; rs1 = 5'd5; rs2 = 5'd5; #1;
    checks++;
    if (read1 !== 32'h12345678 || read2 !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bypass_pre read1=%h read2=%h required 12345678", read1, read2);
    end
    tick();
    checks++;
    if (read1 !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bypass_post read1=%h required 12345678", read1);
    end
    wr = 1'b0; wr_data = 32'h0BADF00D; #1;
    checks++;
    if (read1 !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bypass_hold read1=%h required 12345678", read1);
    end
    tick();
    checks++;
    if (read2 !== 32'h12345678) begin
      errors++; $display("[TB] FAIL no_write_wr0 read2=%h required 12345678", read2);
    end
  endtask

  task automatic test_reset_midcycle();
    rs1 = 5'd10; rs2 = 5'd20;
    rd = 5'd7; wr_data = 32'h77777777; wr = 1'b1;
    #2;
    rst_n = 1'b0;
    clearModel();
    #1;
    checks++;
    if (read1 !== 0 || read2 !== 0) begin
      errors++; $display("[TB] FAIL async_reset read1=%h read2=%h required 0", read1, read2);
    end
    rs1 = 5'd7; #1;
    checks++;
    if (read1 !== 0) begin
      errors++; $display("[TB] FAIL reset_bypass read1=%h required 0", read1);
    end
    tick();
    #2;
    wr = 1'b0;
    rst_n = 1'b1; #1;
    checks++;
    if (read1 !== 0) begin
      errors++; $display("[TB] FAIL lost_write x7=%h required 0", read1);
    end
    rs1 = 5'd10; rs2 = 5'd20; #1;
    checks++;
    if (read1 !== 0 || read2 !== 0) begin
      errors++; $display("[TB] FAIL after_reset read1=%h read2=%h required 0", read1, read2);
    end
    rd = 5'd20; wr_data = 32'h5A5A1234; wr = 1'b1;
    tick();
    wr = 1'b0; #1;
    checks++;
    if (read2 !== 32'h5A5A1234 || read1 !== 0) begin
      errors++; $display("[TB] FAIL first_write read1=%h read2=%h required 00000000 5A5A1234", read1, read2);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      rs1 = ADDR_W'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : ADDR_W'($urandom_range(0, 31));
      rd = ($urandom_range(0, 3) == 0) ? rs1 : ADDR_W'($urandom_range(0, 31));
      wr_data = $urandom;
      wr = ($urandom_range(0, 2) != 0);
      #1;
      e1 = expRead(rs1); e2 = expRead(rs2);
      checks++;
      if (read1 !== e1 || read2 !== e2) begin
        errors++;
        $display("[TB] FAIL rand_pre n=%0d rs1=%0d rs2=%0d read1=%h read2=%h required %h %h", n, rs1, rs2, read1, read2, e1, e2);
      end
      tick();
      e1 = expRead(rs1); e2 = expRead(rs2);
      checks++;
      if (read1 !== e1 || read2 !== e2) begin
        errors++;
        $display("[TB] FAIL rand_post n=%0d rs1=%0d rs2=%0d read1=%h read2=%h required %h %h", n, rs1, rs2, read1, read2, e1, e2);
      end
    end
    wr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = ADDR_W'(i); #1;
      checks++;
      if (read1 !== expRead(rs1)) begin
        errors++; $display("[TB] FAIL sweep x%0d read1=%h required %h", i, read1, expRead(rs1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_reset_midcycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/registradores.md
REGISTRADORES -- requirements
Module: registradores

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register index width, giving 2**ADDR_W = 32 registers.
REQ-003 The block SHALL have port clk  input  1  sole clock; all register writes occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port rs1  input  ADDR_W  read port 1 register index.
REQ-006 The block SHALL have port rs2  input  ADDR_W  read port 2 register index.
REQ-007 The block SHALL have port rd  input  ADDR_W  write register index.
REQ-008 The block SHALL have port wr_data  input  DATA_W  write data.
REQ-009 The block SHALL have port wr  input  1  write enable, active-high.
REQ-010 The block SHALL have port read1  output  DATA_W  contents of register rs1.
REQ-011 The block SHALL have port read2  output  DATA_W  contents of register rs2.

Function
REQ-012 The block SHALL implement a 32 x DATA_W register array, registers x0..x31.
REQ-013 Register x0 SHALL be hardwired to zero: reads of index 0 return 0 regardless of prior writes.
REQ-014 A write to x0 SHALL be discarded with no side effect on any register.
REQ-015 When wr=1 at a rising clk edge and rd!=0, register rd SHALL take the value of wr_data.
REQ-016 When wr=0 at a rising clk edge, no register SHALL change.
REQ-017 Read ports SHALL be combinational with zero-cycle latency; read1 and read2 follow changes on rs1/rs2 within the same cycle.
REQ-018 Both read ports SHALL be independent; rs1==rs2 returns the same value on both.
REQ-019 Write-through bypass: when wr=1, rd!=0 and rs1==rd, read1 SHALL equal wr_data combinationally; the same rule SHALL apply to rs2/read2.
REQ-020 After the write edge, the stored value SHALL equal the value that was bypassed, so outputs do not glitch across the edge.
REQ-021 Exactly one write per cycle SHALL be supported; reads and the write in the same cycle SHALL not interfere except via REQ-019.
REQ-022 Values SHALL be stored bit-exact at DATA_W with no sign extension or truncation.

Reset
REQ-023 When rst_n=0, all registers x1..x31 SHALL clear to 0 immediately, independent of clk.
REQ-024 While rst_n=0, writes SHALL be blocked, and read1/read2 SHALL return 0 for any index, including when the bypass conditions of REQ-019 hold.
REQ-025 On rst_n deassertion, the first rising clk edge with wr=1 SHALL perform a normal write.
REQ-026 When rst_n asserts in the middle of a cycle in which wr=1, the write SHALL be lost and the target register SHALL read 0.

Verification
REQ-027 Reset, then rs1=0, rs2=0 -> read1=0, read2=0; spot-check x1, x15 and x31 all read 0.
REQ-028 rd=10, wr_data=32'hAAAABBBB, wr=1 for one edge, then wr=0, rs1=10, rs2=20 -> read1=32'hAAAABBBB, read2=0.
REQ-029 rd=20, wr_data=32'hCCCCDDDD, wr=1 for one edge, then wr=0, rs1=0, rs2=20 -> read1=0, read2=32'hCCCCDDDD; x10 still reads 32'hAAAABBBB.
REQ-030 rd=0, wr_data=32'hFFFFFFFF, wr=1 for one edge, then rs1=0 -> read1=0.
REQ-031 With wr=1, rd=5, wr_data=32'h12345678, rs1=5 before the edge -> read1=32'h12345678 pre-edge and post-edge; wr_data change with wr=0 after the edge -> read1 unchanged.
REQ-032 Write x10 and x20 with nonzero values, assert rst_n=0 between clk edges -> read1/read2 at indices 10 and 20 read 0 immediately; after deassertion they still read 0 until rewritten.
